// File: rtl/appliance_pkg.sv
// Shared encodings for the appliance front-panel controller.
//   state_t : appliance FSM state; the encoding is driven straight onto state_o
//   event_t : arbitrated single-cycle button event
//   BEEP_CYCLES_DEFAULT : 0.5 s at 50 MHz
package appliance_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_OPEN  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  typedef enum logic [2:0] {
    EV_NONE = 3'd0,
    EV_ON   = 3'd1,
    EV_OFF  = 3'd2,
    EV_ERR  = 3'd3,
    EV_OPEN = 3'd4
  } event_t;

  localparam int unsigned BEEP_CYCLES_DEFAULT = 25_000_000;

endpackage

// File: rtl/appliance_ctrl_fsm_press_arbiter.sv
// Rising-edge press detectors for the four debounced buttons plus a fixed
// priority encoder (err > open > off > on). Lower-priority presses that land
// in the same cycle are dropped.
//   clk, rst_n                       : clock, async active-low reset
//   on_db, off_db, err_db, open_db   : debounced button levels
//   ev                               : encoded event, valid for one cycle
module press_arbiter
  import appliance_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   on_db,
  input  logic   off_db,
  input  logic   err_db,
  input  logic   open_db,
  output event_t ev
);

  logic [3:0] level;
  logic [3:0] prev;
  logic [3:0] press;

  // bit order: {err, open, off, on}
  assign level = {err_db, open_db, off_db, on_db};

  // History resets to 1 so a button held through reset release is not a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= '1;
    else        prev <= level;
  end

  assign press = level & ~prev;

  always_comb begin
    ev = EV_NONE;
    if      (press[3]) ev = EV_ERR;
    else if (press[2]) ev = EV_OPEN;
    else if (press[1]) ev = EV_OFF;
    else if (press[0]) ev = EV_ON;
  end

endmodule

// File: rtl/appliance_ctrl_fsm.sv
// Appliance front-panel controller: four-state FSM, status LEDs, buzzer
// (single beep per transition, toggling alarm in FAULT) and a saturating
// count of IDLE->RUN starts. All outputs are registered.
//   clk_50MHz, reset            : clock, async active-low reset
//   on_db/off_db/err_db/open_db : debounced button levels
//   state_o                     : IDLE=00 RUN=01 OPEN=10 FAULT=11
//   run_led/open_led/err_led    : state indicators
//   buzzer                      : buzzer drive
//   run_count                   : accepted starts, saturating
module appliance_ctrl_fsm
  import appliance_pkg::*;
#(
  parameter int unsigned BEEP_CYCLES = BEEP_CYCLES_DEFAULT,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk_50MHz,
  input  logic             reset,
  input  logic             on_db,
  input  logic             off_db,
  input  logic             err_db,
  input  logic             open_db,
  output logic [1:0]       state_o,
  output logic             run_led,
  output logic             open_led,
  output logic             err_led,
  output logic             buzzer,
  output logic [CNT_W-1:0] run_count
);

  localparam int unsigned BW = $clog2(BEEP_CYCLES + 1);

  event_t           ev;
  state_t           state, state_next;
  logic             accept;
  logic [BW-1:0]    beep_cnt, beep_cnt_next;
  logic             buzzer_next;
  logic             run_led_next, open_led_next, err_led_next;
  logic [CNT_W-1:0] run_count_next;

  press_arbiter u_arb (
    .clk     (clk_50MHz),
    .rst_n   (reset),
    .on_db   (on_db),
    .off_db  (off_db),
    .err_db  (err_db),
    .open_db (open_db),
    .ev      (ev)
  );

  // State register, together with every registered output.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      run_led   <= 1'b0;
      open_led  <= 1'b0;
      err_led   <= 1'b0;
      buzzer    <= 1'b0;
      beep_cnt  <= '0;
      run_count <= '0;
    end else begin
      state     <= state_next;
      run_led   <= run_led_next;
      open_led  <= open_led_next;
      err_led   <= err_led_next;
      buzzer    <= buzzer_next;
      beep_cnt  <= beep_cnt_next;
      run_count <= run_count_next;
    end
  end

  // Next-state logic; every listed event changes state, so any state change
  // is an accepted transition.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        case (ev)
          EV_ON:   state_next = ST_RUN;
          EV_OPEN: state_next = ST_OPEN;
          EV_ERR:  state_next = ST_FAULT;
          default: state_next = state;
        endcase
      end
      ST_RUN: begin
        case (ev)
          EV_OFF:  state_next = ST_IDLE;
          EV_OPEN: state_next = ST_OPEN;
          EV_ERR:  state_next = ST_FAULT;
          default: state_next = state;
        endcase
      end
      ST_OPEN: begin
        case (ev)
          EV_OPEN: state_next = ST_IDLE;
          EV_ERR:  state_next = ST_FAULT;
          default: state_next = state;
        endcase
      end
      ST_FAULT: begin
        // Fault can only be cleared once the fault level itself has dropped.
        if (ev == EV_OFF && !err_db) state_next = ST_IDLE;
      end
    endcase
  end

  assign accept = (state_next != state);

  // Output logic: LEDs decoded from next state, buzzer/beep timer, run counter.
  always_comb begin
    run_led_next   = (state_next == ST_RUN);
    open_led_next  = (state_next == ST_OPEN);
    err_led_next   = (state_next == ST_FAULT);
    buzzer_next    = buzzer;
    beep_cnt_next  = beep_cnt;
    run_count_next = run_count;

    if (accept) begin
      beep_cnt_next = BW'(BEEP_CYCLES);
      buzzer_next   = 1'b1;
    end else if (state == ST_FAULT) begin
      // Alarm: reload and toggle every BEEP_CYCLES cycles.
      if (beep_cnt <= BW'(1)) begin
        beep_cnt_next = BW'(BEEP_CYCLES);
        buzzer_next   = ~buzzer;
      end else begin
        beep_cnt_next = beep_cnt - BW'(1);
      end
    end else if (beep_cnt != '0) begin
      // Single beep: buzzer drops on the edge that takes the count to zero.
      beep_cnt_next = beep_cnt - BW'(1);
      if (beep_cnt == BW'(1)) buzzer_next = 1'b0;
    end

    if (state == ST_IDLE && state_next == ST_RUN && run_count != '1)
      run_count_next = run_count + CNT_W'(1);
  end

  assign state_o = state;

endmodule
